mult_seq_nbit: RTL and testbench



---
 rtl/mult_pkg.sv | 10 +
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/mult_seq_nbit.sv | 89 ++++++++
 tb/tb_mult_seq_nbit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: FSM state type and active-high hex seven-segment patterns (bit order a..g).
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex digit to active-high segments a..g; built only with MULT_SEG_EN.
`ifdef MULT_SEG_EN
module seg7_hex_decoder
  import mult_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_HEX[hex_i];
endmodule
`endif

// File: rtl/mult_seq_nbit.sv
// mult_seq_nbit: WIDTH-bit shift-and-add unsigned multiplier with start/done handshake.
// Defining MULT_SEG_EN adds segment ports a..g showing the low nibble of p.
module mult_seq_nbit
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
`ifdef MULT_SEG_EN
  ,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               f,
  output logic               g
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, p_q, p_d, acc_sum;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, done_q;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        mcand_d  = {{WIDTH{1'b0}}, A};
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = acc_sum;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == DONE;
    end
  end
  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef MULT_SEG_EN
  seg7_hex_decoder u_seg (.hex_i(p_q[3:0]), .seg_o({a, b, c, d, e, f, g}));
`endif
endmodule

// File: tb/tb_mult_seq_nbit.sv
// tb_mult_seq_nbit: WIDTH=4 and WIDTH=2 multipliers against a latency/product model plus literal checks.
module tb_mult_seq_nbit;
  logic clk = 1'b0;
  logic rst, start, chk_en;
  logic [3:0] A4, B4;
  logic [1:0] A2, B2;
  logic [7:0] p4;
  logic [3:0] p2;
  logic busy4, done4, busy2, done2;
  int checks = 0;
  int failures = 0;
  localparam int W [2] = '{4, 2};
  int rem [2];
  logic [7:0] prod [2], mp [2];
  logic mb [2], md [2];
  always #5 clk = ~clk;
  assign A2 = A4[1:0];
  assign B2 = B4[1:0];
`ifdef MULT_SEG_EN
  localparam logic [6:0] SEG_T [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [6:0] seg4, seg2;
`endif
  mult_seq_nbit #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .A(A4), .B(B4), .p(p4), .busy(busy4), .done(done4)
`ifdef MULT_SEG_EN
    , .a(seg4[6]), .b(seg4[5]), .c(seg4[4]), .d(seg4[3]), .e(seg4[2]), .f(seg4[1]), .g(seg4[0])
`endif
  );
  mult_seq_nbit #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .A(A2), .B(B2), .p(p2), .busy(busy2), .done(done2)
`ifdef MULT_SEG_EN
    , .a(seg2[6]), .b(seg2[5]), .c(seg2[4]), .d(seg2[3]), .e(seg2[2]), .f(seg2[1]), .g(seg2[0])
`endif
  );
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: an accepted start completes W edges later with the product, DONE lasts one edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] <= 0; mp[i] <= '0; mb[i] <= 1'b0; md[i] <= 1'b0;
      end else if (md[i]) begin
        md[i] <= 1'b0; mb[i] <= 1'b0;
      end else if (mb[i]) begin
        rem[i] <= rem[i] - 1;
        if (rem[i] == 1) begin
          mp[i] <= prod[i]; md[i] <= 1'b1;
        end
      end else if (start) begin
        mb[i] <= 1'b1;
        rem[i] <= W[i];
        prod[i] <= (i == 0) ? 8'(A4) * 8'(B4) : 8'(A2) * 8'(B2);
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("p4", 32'(p4), 32'(mp[0]));
      check("busy4", 32'(busy4), 32'(mb[0]));
      check("done4", 32'(done4), 32'(md[0]));
      check("p2", 32'(p2), 32'(mp[1]));
      check("busy2", 32'(busy2), 32'(mb[1]));
      check("done2", 32'(done2), 32'(md[1]));
`ifdef MULT_SEG_EN
      check("seg4", 32'(seg4), 32'(SEG_T[p4[3:0]]));
      check("seg2", 32'(seg2), 32'(SEG_T[p2]));
`endif
    end
  end
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat4, output int lat2,
                        output logic [7:0] r4, output logic [3:0] r2);
    A4 = a; B4 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat4 = -1; lat2 = -1; r4 = 'x; r2 = 'x;
    for (int c = 1; c <= 20 && (lat4 < 0 || lat2 < 0); c++) begin
      tick();
      if (done4 && lat4 < 0) begin lat4 = c; r4 = p4; end
      if (done2 && lat2 < 0) begin lat2 = c; r2 = p2; end
    end
    tick();
  endtask
  initial begin
    int l4, l2, nd, last;
    logic [7:0] r4, cap;
    logic [3:0] r2, ra, rb;
    rst = 1'b1; start = 1'b0; A4 = '0; B4 = '0; chk_en = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    check("rst_p4", 32'(p4), 0);
    check("rst_busy4", 32'(busy4), 0);
    check("rst_done4", 32'(done4), 0);
`ifdef MULT_SEG_EN
    check("rst_seg", 32'(seg4), 32'(7'b1111110));
`endif
    rst = 1'b0;
    tick();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        run_op(4'(a), 4'(b), l4, l2, r4, r2);
        check("w2_lat", 32'(l2), 2);
        check("w2_prod", 32'(r2), 32'(a * b));
      end
    run_op(4'd3, 4'd3, l4, l2, r4, r2);
    check("w2_3x3", 32'(r2), 9);
    run_op(4'd2, 4'd3, l4, l2, r4, r2);
    check("w2_2x3", 32'(r2), 6);
    run_op(4'd15, 4'd15, l4, l2, r4, r2);
    check("w4_15x15", 32'(r4), 225);
    check("w4_15x15_lat", 32'(l4), 4);
`ifdef MULT_SEG_EN
    check("seg_e1", 32'(seg4), 32'(7'b0110000));
`endif
    run_op(4'd0, 4'd13, l4, l2, r4, r2);
    check("w4_0x13", 32'(r4), 0);
    check("w4_0x13_lat", 32'(l4), 4);
    run_op(4'd1, 4'd15, l4, l2, r4, r2);
    check("w4_1x15", 32'(r4), 15);
    run_op(4'd3, 4'd1, l4, l2, r4, r2);
    check("w4_3x1", 32'(r4), 3);
`ifdef MULT_SEG_EN
    check("seg_3", 32'(seg4), 32'(7'b1111001));
`endif
    A4 = 4'd5; B4 = 4'd6; start = 1'b1;
    tick();
    A4 = 4'd7; B4 = 4'd7;
    nd = 0; cap = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) start = 1'b0;
      tick();
      if (done4) begin nd++; cap = p4; end
    end
    check("busy_ndone", 32'(nd), 1);
    check("busy_prod", 32'(cap), 30);
    A4 = 4'd9; B4 = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_p", 32'(p4), 0);
    check("midrst_busy", 32'(busy4), 0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done4) nd++;
    end
    check("midrst_ndone", 32'(nd), 0);
    run_op(4'd3, 4'd4, l4, l2, r4, r2);
    check("after_rst_3x4", 32'(r4), 12);
    A4 = 4'd2; B4 = 4'd5; start = 1'b1;
    last = -1; nd = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done4) begin
        nd++;
        check("b2b_prod", 32'(p4), 10);
        if (last >= 0) check("b2b_period", 32'(c - last), 6);
        last = c;
      end
    end
    check("b2b_count", 32'(nd >= 4), 1);
    start = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      run_op(ra, rb, l4, l2, r4, r2);
      check("rand_prod", 32'(r4), 32'(ra) * 32'(rb));
      check("rand_lat", 32'(l4), 4);
    end
    for (int i = 0; i < 400; i++) begin
      start = 1'($urandom_range(0, 1));
      A4 = 4'($urandom); B4 = 4'($urandom);
      rst = ($urandom_range(0, 40) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
